echo_emulator: RTL

Ultrasonic sensor emulator: the responder end of the trigger/echo interface driven by the distance-measurement top level. It watches the outgoing `stimulus` trigger, waits a round-trip delay proportional to a programmed target distance, then returns an echo edge on `cathode`. This lets the measurement chain be exercised on the board, without a transducer, with known distances.

---
 rtl/echo_emulator_if.sv | 25 ++
 rtl/echo_emulator.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/echo_emulator_if.sv
// Trigger/echo bundle between the distance-measurement side (master) and the
// ultrasonic sensor emulator (slave).
interface echo_emulator_if;
    logic       stimulus;
    logic [8:0] distance_cm;
    logic       cathode;
    logic       busy;
    logic       trig_drop;

    modport master (
        output stimulus,
        output distance_cm,
        input  cathode,
        input  busy,
        input  trig_drop
    );

    modport slave (
        input  stimulus,
        input  distance_cm,
        output cathode,
        output busy,
        output trig_drop
    );
endinterface

// File: rtl/echo_emulator.sv
// Ultrasonic sensor emulator: answers a trigger pulse with an echo pulse after
// a round-trip delay proportional to the programmed target distance, followed
// by a dead time during which further triggers are flagged and ignored.
module echo_emulator #(
    parameter int unsigned CYCLES_PER_CM = 5882,
    parameter int unsigned TRIG_MIN      = 1000,
    parameter int unsigned ECHO_W        = 100,
    parameter int unsigned MAX_CM        = 400,
    parameter int unsigned HOLDOFF       = 6000000
) (
    input  logic            system_clk,
    input  logic            reset,
    echo_emulator_if.slave  bus
);

    // One shared counter times the cm prescaler, the echo width and the holdoff.
    localparam int unsigned PRE_MAX0 = (HOLDOFF > CYCLES_PER_CM) ? HOLDOFF : CYCLES_PER_CM;
    localparam int unsigned PRE_MAX  = (PRE_MAX0 > ECHO_W) ? PRE_MAX0 : ECHO_W;
    localparam int unsigned PRE_W    = $clog2(PRE_MAX + 1);
    localparam int unsigned WID_W    = $clog2(TRIG_MIN + 1);

    localparam logic [PRE_W-1:0] CPC_LAST  = PRE_W'(CYCLES_PER_CM - 1);
    localparam logic [PRE_W-1:0] ECHO_LAST = PRE_W'(ECHO_W - 1);
    localparam logic [PRE_W-1:0] HOLD_LAST = PRE_W'(HOLDOFF - 1);
    localparam logic [WID_W-1:0] TRIG_LIM  = WID_W'(TRIG_MIN);
    localparam logic [8:0]       MAX_CM_W  = 9'(MAX_CM);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TRIG  = 3'd1,
        DELAY = 3'd2,
        ECHO  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               s1_q, s2_q, s2_prev_q;
    logic [WID_W-1:0]   wid_q, wid_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [8:0]         cm_q, cm_d;
    logic [8:0]         d_lat_q, d_lat_d;
    logic               cathode_q, cathode_d;
    logic               busy_q, busy_d;
    logic               trig_drop_q, trig_drop_d;

    logic               s2_rise;
    logic               in_measure;

    assign s2_rise    = s2_q & ~s2_prev_q;
    assign in_measure = (state_q == DELAY) || (state_q == ECHO) || (state_q == HOLD);

    assign bus.cathode   = cathode_q;
    assign bus.busy      = busy_q;
    assign bus.trig_drop = trig_drop_q;

    // Two-flop synchronizer for the asynchronous trigger plus one delayed copy for edges.
    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s2_prev_q <= 1'b0;
        end else begin
            s1_q      <= bus.stimulus;
            s2_q      <= s1_q;
            s2_prev_q <= s2_q;
        end
    end

    // Next-state logic: trigger qualification, distance delay, echo and holdoff timing.
    always_comb begin
        state_d     = state_q;
        wid_d       = wid_q;
        pre_d       = pre_q;
        cm_d        = cm_q;
        d_lat_d     = d_lat_q;

        case (state_q)
            IDLE: begin
                // Only a fresh rising edge starts a trigger; a level already high does not.
                if (s2_rise) begin
                    state_d = TRIG;
                    wid_d   = WID_W'(1);
                end
            end
            TRIG: begin
                if (s2_q) begin
                    if (wid_q < TRIG_LIM) begin
                        wid_d = wid_q + WID_W'(1);
                    end
                end else begin
                    // Falling edge of the trigger: qualify its width and latch the distance.
                    wid_d = '0;
                    pre_d = '0;
                    cm_d  = '0;
                    if (wid_q >= TRIG_LIM) begin
                        d_lat_d = bus.distance_cm;
                        if ((bus.distance_cm != 9'd0) && (bus.distance_cm <= MAX_CM_W)) begin
                            state_d = DELAY;
                        end else begin
                            state_d = HOLD;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DELAY: begin
                // Prescaler wraps once per cm; cm counter reaching d_lat ends the delay.
                if (pre_q == CPC_LAST) begin
                    pre_d = '0;
                    if ((cm_q + 9'd1) == d_lat_q) begin
                        cm_d    = '0;
                        state_d = ECHO;
                    end else begin
                        cm_d = cm_q + 9'd1;
                    end
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            ECHO: begin
                if (pre_q == ECHO_LAST) begin
                    pre_d   = '0;
                    state_d = HOLD;
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            HOLD: begin
                if (pre_q == HOLD_LAST) begin
                    pre_d   = '0;
                    state_d = IDLE;
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                wid_d   = '0;
                pre_d   = '0;
                cm_d    = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state change.
        cathode_d   = (state_d == ECHO);
        busy_d      = (state_d == DELAY) || (state_d == ECHO) || (state_d == HOLD);
        trig_drop_d = s2_rise && in_measure;
    end

    // State, counters and registered outputs; reset clears outputs without a clock edge.
    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wid_q       <= '0;
            pre_q       <= '0;
            cm_q        <= '0;
            d_lat_q     <= '0;
            cathode_q   <= 1'b0;
            busy_q      <= 1'b0;
            trig_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wid_q       <= wid_d;
            pre_q       <= pre_d;
            cm_q        <= cm_d;
            d_lat_q     <= d_lat_d;
            cathode_q   <= cathode_d;
            busy_q      <= busy_d;
            trig_drop_q <= trig_drop_d;
        end
    end

endmodule
